fnd_display_ctrl: RTL and testbench



---
 rtl/fnd_display_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fnd_display_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fnd_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fnd_display_ctrl
// Purpose  : Converts a 14-bit stopwatch count (clamped to 0..9999) to four
//            BCD digits with a sequential double-dabble engine and scans them
//            onto a 4-digit common-anode 7-segment display. The displayed
//            digit set is swapped atomically when a conversion completes.
// Ports    : clk      - system clock
//            reset    - synchronous active-high reset
//            value    - binary count in (values above 9999 clamp to 9999)
//            fndCom   - active-low one-hot digit enable, bit0 = ones digit
//            fndFont  - active-low segments {dp,g,f,e,d,c,b,a}
//            busy     - high while a conversion is in progress
// Options  : FND_LZB_EN - leading-zero blanking on digit positions 1..3
// Revision : 1.0 - initial release
// ============================================================================
module fnd_display_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] value,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont,
  output logic        busy
);

  localparam int              SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int              DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [13:0]     MAX_VAL    = 14'd9999;
  localparam logic [3:0]      SHIFT_LAST = 4'd13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [13:0]       snap_q;
  logic [13:0]       bin_q;
  logic [15:0]       bcd_q;
  logic [3:0]        shcnt_q;
  logic [3:0][3:0]   d_q;
  logic              busy_q;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        com_q;
  logic [7:0]        font_q;

  logic [13:0]       clamped_w;
  logic [15:0]       bcd_adj_w;
  logic [3:0][3:0]   d_d;
  logic              blank_w;
  logic [7:0]        font_w;

  function automatic logic [7:0] seg7(input logic [3:0] dig);
    case (dig)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 would overflow past 9 on the
  // following shift, so pre-add 3.
  function automatic logic [15:0] dabble_adj(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < 4; n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    clamped_w = (value > MAX_VAL) ? MAX_VAL : value;
    bcd_adj_w = dabble_adj(bcd_q);
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      shcnt_q <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clamped_w != snap_q) begin
            snap_q  <= clamped_w;
            bin_q   <= clamped_w;
            bcd_q   <= '0;
            shcnt_q <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // {bcd,bin} shifted left by one after the correction step
          bcd_q   <= {bcd_adj_w[14:0], bin_q[13]};
          bin_q   <= {bin_q[12:0], 1'b0};
          shcnt_q <= shcnt_q + 4'd1;
          if (shcnt_q == SHIFT_LAST) state_q <= DONE;
        end
        DONE: begin
          d_q     <= bcd_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- Scan
  // Next-cycle digit set and scan index feed the registered outputs so that
  // fndFont always matches the digit selected by fndCom with no extra lag.
  always_comb begin
    d_d   = (state_q == DONE) ? bcd_q : d_q;
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    idx_d = (div_q == DIV_LAST) ? idx_q + 2'd1 : idx_q;
  end

`ifdef FND_LZB_EN
  // Position k >= 1 blanks when it and every higher digit are zero.
  always_comb begin
    blank_w = (idx_d != 2'd0);
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) >= idx_d) && (d_d[j] != 4'd0)) blank_w = 1'b0;
    end
  end
`else
  always_comb begin
    blank_w = 1'b0;
  end
`endif

  always_comb begin
    font_w = blank_w ? 8'hFF : seg7(d_d[idx_d]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      idx_q  <= 2'd0;
      com_q  <= 4'b1110;
      font_q <= 8'hC0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      com_q  <= ~(4'b0001 << idx_d);
      font_q <= font_w;
    end
  end

  assign fndCom  = com_q;
  assign fndFont = font_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_display_ctrl.sv
`default_nettype none
module tb_fnd_display_ctrl;

  localparam int CLK_HZ   = 1000;
  localparam int SCAN_HZ  = 100;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
`ifdef FND_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] value = '0;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;
  logic        busy;

  always #5 clk = ~clk;

  fnd_display_ctrl #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .value  (value),
    .fndCom (fndCom),
    .fndFont(fndFont),
    .busy   (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Conversion modelled as a countdown: a captured number becomes visible
  // 15 clocks after the capture edge, busy is high while counting.
  int m_snap, m_pend, m_cnt, m_disp, m_div, m_idx, m_c;
  bit m_live = 1'b0;

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: seg = 8'hC0; 1: seg = 8'hF9; 2: seg = 8'hA4; 3: seg = 8'hB0;
      4: seg = 8'h99; 5: seg = 8'h92; 6: seg = 8'h82; 7: seg = 8'hF8;
      8: seg = 8'h80; 9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_font(input int num, input int k);
    int p = 1;
    repeat (k) p = p * 10;
    if (LZB && k >= 1 && num < p) return 8'hFF;
    return seg((num / p) % 10);
  endfunction

  function automatic logic [3:0] exp_com(input int k);
    return ~(4'b0001 << k);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_snap = 0; m_pend = 0; m_cnt = 0; m_disp = 0; m_div = 0; m_idx = 0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (m_cnt == 0) begin
        m_c = (int'(value) > 9999) ? 9999 : int'(value);
        if (m_c != m_snap) begin
          m_snap = m_c;
          m_pend = m_c;
          m_cnt  = 15;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_disp = m_pend;
      end
      if (m_div == SCAN_DIV - 1) begin
        m_div = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_div = m_div + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model busy", busy, (m_cnt != 0));
      check("model fndCom", fndCom, exp_com(m_idx));
      check("model fndFont", fndFont, exp_font(m_disp, m_idx));
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_digits(input string nm, input logic [7:0] f0, input logic [7:0] f1,
                               input logic [7:0] f2, input logic [7:0] f3);
    logic [7:0] f [4];
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    for (int k = 0; k < 4; k++) begin
      int t = 0;
      logic [3:0] want = ~(4'b0001 << k);
      while (fndCom !== want && t < 8 * SCAN_DIV) begin
        @(negedge clk);
        t++;
      end
      check({nm, " com"}, fndCom, want);
      check({nm, " font"}, fndFont, f[k]);
    end
  endtask

  task automatic count_busy(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int bc;
    reset = 1'b1;
    value = 14'd0;
    step(3);
    check("reset fndCom", fndCom, 4'b1110);
    check("reset fndFont", fndFont, 8'hC0);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;
    step(9);
    check("scan before tc", fndCom, 4'b1110);
    step(1);
    check("scan after 10 clk", fndCom, 4'b1101);

    // basic conversion
    value = 14'd1234;
    count_busy(25, bc);
    check("busy length 1234", bc, 15);
    expect_digits("d1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // clamp: 16383 clamps to the snapshot value, so no new conversion
    value = 14'd9999;
    step(25);
    expect_digits("d9999", 8'h90, 8'h90, 8'h90, 8'h90);
    value = 14'h3FFF;
    count_busy(25, bc);
    check("clamp no conversion", bc, 0);
    expect_digits("dclamp", 8'h90, 8'h90, 8'h90, 8'h90);

    // change during the 5th SHIFT cycle
    value = 14'd1234;
    step(5);
    value = 14'd5678;
    step(11);
    check("first conv done busy", busy, 1'b0);
    step(1);
    check("second conv started", busy, 1'b1);
    step(20);
    expect_digits("d5678", 8'h80, 8'hF8, 8'h82, 8'h92);

    // reset during the 7th SHIFT cycle
    value = 14'd1111;
    step(7);
    check("busy mid shift", busy, 1'b1);
    reset = 1'b1;
    step(1);
    check("abort busy", busy, 1'b0);
    check("abort fndFont", fndFont, 8'hC0);
    check("abort fndCom", fndCom, 4'b1110);
    reset = 1'b0;
    step(1);
    check("restart after release", busy, 1'b1);
    step(20);
    expect_digits("d1111", 8'hF9, 8'hF9, 8'hF9, 8'hF9);

    // leading-zero behaviour
    value = 14'd42;
    step(20);
    if (LZB) expect_digits("d42", 8'hA4, 8'h99, 8'hFF, 8'hFF);
    else     expect_digits("d42", 8'hA4, 8'h99, 8'hC0, 8'hC0);
    value = 14'd0;
    step(20);
    if (LZB) expect_digits("d0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
    else     expect_digits("d0", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

    // randomized values and hold times, occasional reset
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) value = 14'($urandom_range(9990, 16383));
      else                           value = 14'($urandom_range(0, 9999));
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      step($urandom_range(1, 40));
    end
    step(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
